// File: rtl/trig_cmd_pkg.sv
// Shared types and defaults for the triplicated trigger-command detector.
package trig_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_ID   = 2'd2
  } fsm_e;

  localparam logic [2:0] L1_CODE_DEF = 3'b110;
  localparam logic [2:0] R3_CODE_DEF = 3'b101;

  // Start bit plus type field plus ID field.
  function automatic int frame_len(input int hdr_w, input int id_w);
    return 1 + hdr_w + id_w;
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter with a flag raised when any replica disagrees.
module tmr_vote #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic [WIDTH-1:0] vote_o,
  output logic             mismatch_o
);

  assign vote_o     = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
  assign mismatch_o = |((in_a ^ in_b) | (in_a ^ in_c));

endmodule

// File: rtl/trig_cmd_detect_tmr.sv
// Triplicated serial L1/R3 command detector; every state flop is voted and fed back each cycle.
//   state | meaning
//   IDLE  | waiting for a start bit
//   HDR   | shifting in the type code
//   ID    | shifting in the ID field
module trig_cmd_detect_tmr
  import trig_cmd_pkg::*;
#(
  parameter int                   ID_WIDTH     = 8,
  parameter int                   HDR_WIDTH    = 3,
  parameter logic [HDR_WIDTH-1:0] L1_CODE      = HDR_WIDTH'(L1_CODE_DEF),
  parameter logic [HDR_WIDTH-1:0] R3_CODE      = HDR_WIDTH'(R3_CODE_DEF),
  parameter int                   ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    Resetb,
  input  logic                    det_en,
  input  logic                    cmd_in,
  input  logic                    cnt_clr,
  output logic                    l1_ack,
  output logic [ID_WIDTH-1:0]     l1_id,
  output logic                    r3_ack,
  output logic [ID_WIDTH-1:0]     r3_id,
  output logic                    cmd_err,
  output logic                    seu_err,
  output logic [ERRCNT_WIDTH-1:0] seu_cnt
);

  localparam int SH_W = (ID_WIDTH > HDR_WIDTH) ? ID_WIDTH : HDR_WIDTH;
  localparam int CW   = (SH_W > 1) ? $clog2(SH_W) : 1;
  localparam int ST_W = 2 + CW + SH_W + 1 + 2 * ID_WIDTH + 3 + ERRCNT_WIDTH;

  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_WIDTH - 1);
  localparam logic [CW-1:0] ID_LAST  = CW'(ID_WIDTH - 1);

  logic [3*ST_W-1:0]       rep_all;
  logic [ST_W-1:0]         st_v;
  logic                    mismatch;

  logic [1:0]              v_fsm;
  logic [CW-1:0]           v_bcnt;
  logic [SH_W-1:0]         v_shift;
  logic                    v_is_l1;
  logic [ID_WIDTH-1:0]     v_l1_id;
  logic [ID_WIDTH-1:0]     v_r3_id;
  logic                    v_l1_ack;
  logic                    v_r3_ack;
  logic                    v_cmd_err;
  logic [ERRCNT_WIDTH-1:0] v_cnt;

  logic                    seu_err_d;
  logic                    seu_err_q;

  assign {v_fsm, v_bcnt, v_shift, v_is_l1, v_l1_id, v_r3_id,
          v_l1_ack, v_r3_ack, v_cmd_err, v_cnt} = st_v;

  // Each replica computes its next state from the voted state, so an upset in one copy is overwritten next edge.
  for (genvar r = 0; r < 3; r++) begin : g_rep
    logic [ST_W-1:0]         st_d;
    logic [ST_W-1:0]         st_q;
    logic [ST_W-1:0]         st_o;
    fsm_e                    fsm_n;
    logic [CW-1:0]           bcnt_n;
    logic [SH_W-1:0]         shift_in;
    logic [SH_W-1:0]         shift_n;
    logic                    is_l1_n;
    logic [ID_WIDTH-1:0]     l1_id_n;
    logic [ID_WIDTH-1:0]     r3_id_n;
    logic                    l1_ack_n;
    logic                    r3_ack_n;
    logic                    cmd_err_n;
    logic [ERRCNT_WIDTH-1:0] cnt_n;

    always_comb begin
      shift_in  = {v_shift[SH_W-2:0], cmd_in};
      fsm_n     = fsm_e'(v_fsm);
      bcnt_n    = v_bcnt;
      shift_n   = v_shift;
      is_l1_n   = v_is_l1;
      l1_id_n   = v_l1_id;
      r3_id_n   = v_r3_id;
      l1_ack_n  = 1'b0;
      r3_ack_n  = 1'b0;
      cmd_err_n = 1'b0;

      if (!det_en) begin
        fsm_n  = ST_IDLE;
        bcnt_n = '0;
      end else begin
        case (v_fsm)
          ST_IDLE: begin
            if (cmd_in) begin
              fsm_n  = ST_HDR;
              bcnt_n = '0;
            end
          end
          ST_HDR: begin
            shift_n = shift_in;
            bcnt_n  = v_bcnt + 1'b1;
            if (v_bcnt == HDR_LAST) begin
              bcnt_n = '0;
              if (shift_in[HDR_WIDTH-1:0] == L1_CODE || shift_in[HDR_WIDTH-1:0] == R3_CODE) begin
                fsm_n   = ST_ID;
                is_l1_n = (shift_in[HDR_WIDTH-1:0] == L1_CODE);
              end else begin
                fsm_n     = ST_IDLE;
                cmd_err_n = 1'b1;
              end
            end
          end
          ST_ID: begin
            shift_n = shift_in;
            bcnt_n  = v_bcnt + 1'b1;
            if (v_bcnt == ID_LAST) begin
              fsm_n  = ST_IDLE;
              bcnt_n = '0;
              if (v_is_l1) begin
                l1_id_n  = shift_in[ID_WIDTH-1:0];
                l1_ack_n = 1'b1;
              end else begin
                r3_id_n  = shift_in[ID_WIDTH-1:0];
                r3_ack_n = 1'b1;
              end
            end
          end
          default: begin
            fsm_n  = ST_IDLE;
            bcnt_n = '0;
          end
        endcase
      end

      // Clear beats a coincident increment; the counter saturates at all-ones.
      if (cnt_clr)
        cnt_n = '0;
      else if (seu_err_q && (v_cnt != '1))
        cnt_n = v_cnt + 1'b1;
      else
        cnt_n = v_cnt;

      st_d = {fsm_n, bcnt_n, shift_n, is_l1_n, l1_id_n, r3_id_n,
              l1_ack_n, r3_ack_n, cmd_err_n, cnt_n};
    end

    always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb)
        st_q <= '0;
      else
        st_q <= st_d;
    end

    assign st_o                    = st_q;
    assign rep_all[r*ST_W +: ST_W] = st_o;
  end

  tmr_vote #(
    .WIDTH(ST_W)
  ) u_vote (
    .in_a       (rep_all[0 +: ST_W]),
    .in_b       (rep_all[ST_W +: ST_W]),
    .in_c       (rep_all[2*ST_W +: ST_W]),
    .vote_o     (st_v),
    .mismatch_o (mismatch)
  );

  always_comb begin
    seu_err_d = mismatch;
  end

  always_ff @(posedge clk or negedge Resetb) begin
    if (!Resetb)
      seu_err_q <= 1'b0;
    else
      seu_err_q <= seu_err_d;
  end

  assign l1_ack  = v_l1_ack;
  assign l1_id   = v_l1_id;
  assign r3_ack  = v_r3_ack;
  assign r3_id   = v_r3_id;
  assign cmd_err = v_cmd_err;
  assign seu_err = seu_err_q;
  assign seu_cnt = v_cnt;

endmodule

// File: tb/tb_trig_cmd_detect_tmr.sv
// Directed bench for trig_cmd_detect_tmr: frames are driven bit-serially, expected acks are
// queued when a frame starts and matched cycle-exactly by a negedge monitor.
module tb_trig_cmd_detect_tmr;

  logic       clk    = 1'b0;
  logic       Resetb = 1'b1;
  logic       det_en = 1'b0;
  logic       cmd_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       l1_ack;
  logic [7:0] l1_id;
  logic       r3_ack;
  logic [7:0] r3_id;
  logic       cmd_err;
  logic       seu_err;
  logic [7:0] seu_cnt;

  typedef struct {
    int         cyc;
    logic [2:0] flags;   // {l1_ack, r3_ack, cmd_err}
    logic [7:0] id;
  } exp_t;

  exp_t        sb[$];
  int          cyc        = 0;
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          seu_cycles = 0;
  logic [40:0] flip_val;
  logic [2:0]  mon_obs;
  logic [2:0]  mon_req;
  exp_t        mon_it;

  trig_cmd_detect_tmr dut (
    .clk     (clk),
    .Resetb  (Resetb),
    .det_en  (det_en),
    .cmd_in  (cmd_in),
    .cnt_clr (cnt_clr),
    .l1_ack  (l1_ack),
    .l1_id   (l1_id),
    .r3_ack  (r3_ack),
    .r3_id   (r3_id),
    .cmd_err (cmd_err),
    .seu_err (seu_err),
    .seu_cnt (seu_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  always @(negedge clk) begin
    mon_req = 3'b000;
    mon_it  = '{cyc: 0, flags: 3'b000, id: 8'h00};
    if (sb.size() > 0) begin
      if (sb[0].cyc == cyc) begin
        mon_it  = sb.pop_front();
        mon_req = mon_it.flags;
      end
    end
    mon_obs = {l1_ack, r3_ack, cmd_err};
    if (mon_obs !== 3'b000 || mon_req !== 3'b000) begin
      check("ack_flags", 32'(mon_obs), 32'(mon_req));
      if (mon_req[2]) check("l1_id_at_ack", 32'(l1_id), 32'(mon_it.id));
      if (mon_req[1]) check("r3_id_at_ack", 32'(r3_id), 32'(mon_it.id));
    end
    if (seu_err === 1'b1) seu_cycles++;
  end

  task automatic force_rep1();
    flip_val = dut.g_rep[1].st_o ^ (41'd1 << 39);
    force dut.g_rep[1].st_o = flip_val;
  endtask

  task automatic release_rep1();
    release dut.g_rep[1].st_o;
  endtask

  // Drives n bits MSB first, one per negedge; optionally queues the expected response
  // (lat cycles after the start bit) and upsets replica 1 while bit flip_at is on the line.
  task automatic drive_bits(input logic [31:0] bits, input int n, input int flip_at,
                            input logic [2:0] req_flags, input logic [7:0] req_id, input int lat);
    logic forced;
    exp_t e;
    forced = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      if (forced) begin
        release_rep1();
        forced = 1'b0;
      end
      if (i == n - 1 && req_flags != 3'b000) begin
        e.cyc   = cyc + lat;
        e.flags = req_flags;
        e.id    = req_id;
        sb.push_back(e);
      end
      if (i == flip_at) begin
        force_rep1();
        forced = 1'b1;
      end
      cmd_in = bits[i];
    end
    if (forced) begin
      @(negedge clk);
      release_rep1();
      cmd_in = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [2:0] code, input logic [7:0] id, input int flip_at);
    if (code == 3'b110)
      drive_bits({20'd0, 1'b1, code, id}, 12, flip_at, 3'b100, id, 12);
    else if (code == 3'b101)
      drive_bits({20'd0, 1'b1, code, id}, 12, flip_at, 3'b010, id, 12);
    else
      drive_bits({28'd0, 1'b1, code}, 4, flip_at, 3'b001, 8'h00, 4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_in = 1'b0;
    end
  endtask

  initial begin
    #2 Resetb = 1'b0;
    #1;
    check("reset_outputs",
          32'({l1_ack, l1_id, r3_ack, r3_id, cmd_err, seu_err, seu_cnt}), 32'd0);
    repeat (3) @(negedge clk);
    Resetb = 1'b1;
    det_en = 1'b1;
    idle(2);

    // L1 frame, then R3 frame
    send_frame(3'b110, 8'hA5, -1);
    idle(3);
    check("t1_l1_id", 32'(l1_id), 32'h0000_00A5);
    check("t1_r3_id", 32'(r3_id), 32'h0000_0000);
    send_frame(3'b101, 8'h3C, -1);
    idle(3);
    check("t2_r3_id", 32'(r3_id), 32'h0000_003C);
    check("t2_l1_id", 32'(l1_id), 32'h0000_00A5);

    // unknown type followed immediately by an L1 frame
    send_frame(3'b011, 8'h00, -1);
    send_frame(3'b110, 8'h01, -1);
    idle(3);
    check("t3_l1_id", 32'(l1_id), 32'h0000_0001);
    check("t3_r3_id", 32'(r3_id), 32'h0000_003C);

    // back-to-back L1 frames
    send_frame(3'b110, 8'h12, -1);
    send_frame(3'b110, 8'h34, -1);
    idle(3);
    check("t6_l1_id", 32'(l1_id), 32'h0000_0034);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    check("no_seu_yet", 32'(seu_cycles), 32'd0);

    // single replica upset inside the ID field
    send_frame(3'b101, 8'h5A, 6);
    idle(4);
    check("t4_r3_id", 32'(r3_id), 32'h0000_005A);
    check("t4_seu_cycles", 32'(seu_cycles), 32'd1);
    check("t4_seu_cnt", 32'(seu_cnt), 32'd1);

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      force_rep1();
      @(negedge clk);
      release_rep1();
      @(negedge clk);
    end
    idle(3);
    check("t4_seu_cycles_300", 32'(seu_cycles), 32'd301);
    check("t4_seu_cnt_sat", 32'(seu_cnt), 32'd255);

    @(negedge clk);
    force_rep1();
    @(negedge clk);
    release_rep1();
    check("t4_seu_pulse", 32'(seu_err), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("t4_clr_wins", 32'(seu_cnt), 32'd0);
    @(negedge clk);
    check("t4_clr_hold", 32'(seu_cnt), 32'd0);
    check("t4_seu_off", 32'(seu_err), 32'd0);

    // reset mid-ID: start, L1 type, three ID bits
    drive_bits(32'b111_0101, 7, -1, 3'b000, 8'h00, 0);
    #2;
    Resetb = 1'b0;
    cmd_in = 1'b0;
    #1;
    check("t5_reset_outputs",
          32'({l1_ack, l1_id, r3_ack, r3_id, cmd_err, seu_err, seu_cnt}), 32'd0);
    @(negedge clk);
    Resetb = 1'b1;
    idle(20);
    check("t5_l1_id_after_reset", 32'(l1_id), 32'd0);

    // det_en abort mid-frame
    send_frame(3'b110, 8'h5A, -1);
    send_frame(3'b101, 8'hC3, -1);
    idle(2);
    drive_bits(32'b1110_1111, 8, -1, 3'b000, 8'h00, 0);
    @(negedge clk);
    det_en = 1'b0;
    cmd_in = 1'b0;
    @(negedge clk);
    det_en = 1'b1;
    idle(20);
    check("t5_abort_l1_id", 32'(l1_id), 32'h0000_005A);
    check("t5_abort_r3_id", 32'(r3_id), 32'h0000_00C3);
    send_frame(3'b101, 8'h66, -1);
    idle(3);
    check("t5_post_abort_r3_id", 32'(r3_id), 32'h0000_0066);
    check("t5_post_abort_l1_id", 32'(l1_id), 32'h0000_005A);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
